mux_sel_sequencer: RTL and testbench

Controller that sits directly around the 16:1 mux stage.
- Upstream: latches a 16-bit word onto the mux data input and steps the mux select through a programmable number of positions.
- Downstream: samples the mux output and emits one bit per position on a valid/ready serial stream.
- Converts the combinational 16:1 mux into a paced parallel-to-serial converter.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_16x1.sv | 10 +
 rtl/mux_sel_sequencer.sv | 106 ++++++++++
 tb/tb_mux_sel_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Constants and FSM state type shared by the mux stage and its sequencer.
package mux_pkg;
    localparam int unsigned MUX_SEL_W = 4;
    localparam int unsigned MUX_WIDTH = 2 ** MUX_SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND,
        DONE
    } state_t;
endpackage

// File: rtl/mux_16x1.sv
// Combinational 16:1 mux stage driven by the sequencer.
module mux_16x1
    import mux_pkg::*;
(
    input  logic [MUX_WIDTH-1:0] in,
    input  logic [MUX_SEL_W-1:0] sel,
    output logic                 out
);
    assign out = in[sel];
endmodule

// File: rtl/mux_sel_sequencer.sv
// Paces the 16:1 mux select through a latched word and streams one bit per
// position on a valid/ready serial interface.
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH     = MUX_WIDTH,
    parameter int unsigned SEL_W     = MUX_SEL_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W:0]   count,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] mux_in_d;
    logic [SEL_W-1:0] mux_sel_d;
    logic [SEL_W:0]   n_left_q, n_left_d;
    logic             ser_bit_d, ser_valid_d, ser_last_d, busy_d, done_d;
    logic [SEL_W:0]   count_clip;

    // Zero or oversize requests send the full word.
    assign count_clip = (count == '0 || 32'(count) > WIDTH) ? (SEL_W+1)'(WIDTH) : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mux_in    <= '0;
            mux_sel   <= '0;
            n_left_q  <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_in    <= mux_in_d;
            mux_sel   <= mux_sel_d;
            n_left_q  <= n_left_d;
            ser_bit   <= ser_bit_d;
            ser_valid <= ser_valid_d;
            ser_last  <= ser_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mux_in_d    = mux_in;
        mux_sel_d   = mux_sel;
        n_left_d    = n_left_q;
        ser_bit_d   = ser_bit;
        ser_valid_d = ser_valid;
        ser_last_d  = ser_last;
        busy_d      = busy;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mux_in_d  = data_in;
                    n_left_d  = count_clip;
                    mux_sel_d = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
                    busy_d    = 1'b1;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                ser_bit_d   = mux_out;
                ser_valid_d = 1'b1;
                ser_last_d  = (n_left_q == (SEL_W+1)'(1));
                state_d     = SEND;
            end
            SEND: begin
                if (ser_valid && ser_ready) begin
                    ser_valid_d = 1'b0;
                    n_left_d    = n_left_q - (SEL_W+1)'(1);
                    // done is registered so it is high exactly while in DONE.
                    if (ser_last) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        mux_sel_d = MSB_FIRST ? mux_sel - SEL_W'(1) : mux_sel + SEL_W'(1);
                        state_d   = SETTLE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: one LSB-first and one MSB-first sequencer, each feeding a mux_16x1.
module tb_mux_sel_sequencer;
    import mux_pkg::*;

    typedef struct packed {
        logic       b;
        logic       last;
        logic [3:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        st[2];
    logic [15:0] din[2];
    logic [4:0]  cnt[2];
    logic        rdy[2];
    logic [15:0] min[2];
    logic [3:0]  sel[2];
    logic        mo[2], sb[2], sv[2], sl[2], bsy[2], dn[2];

    exp_t        q[2][$];
    logic [15:0] word[2];
    int          hs[2];
    int          dones[2];
    int          pass = 0;
    int          total = 0;

    mux_sel_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .data_in(din[0]), .count(cnt[0]),
        .mux_in(min[0]), .mux_sel(sel[0]), .mux_out(mo[0]), .ser_bit(sb[0]),
        .ser_valid(sv[0]), .ser_ready(rdy[0]), .ser_last(sl[0]), .busy(bsy[0]), .done(dn[0])
    );
    mux_16x1 mux0 (.in(min[0]), .sel(sel[0]), .out(mo[0]));

    mux_sel_sequencer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .data_in(din[1]), .count(cnt[1]),
        .mux_in(min[1]), .mux_sel(sel[1]), .mux_out(mo[1]), .ser_bit(sb[1]),
        .ser_valid(sv[1]), .ser_ready(rdy[1]), .ser_last(sl[1]), .busy(bsy[1]), .done(dn[1])
    );
    mux_16x1 mux1 (.in(min[1]), .sel(sel[1]), .out(mo[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        logic       hold_v = 1'b0;
        logic [5:0] hold;
        exp_t       e;
        always @(negedge clk) begin
            if (rst_n && sv[g]) begin
                if (hold_v) chk($sformatf("stall_hold%0d", g), {26'd0, sb[g], sl[g], sel[g]}, {26'd0, hold});
                if (rdy[g]) begin
                    hold_v = 1'b0;
                    if (q[g].size() == 0) begin
                        total++;
                        $display("FAIL extra_bit%0d: got bit %0b with no expected entry", g, sb[g]);
                    end else begin
                        e = q[g].pop_front();
                        chk($sformatf("ser_bit%0d", g), {31'd0, sb[g]}, {31'd0, e.b});
                        chk($sformatf("ser_last%0d", g), {31'd0, sl[g]}, {31'd0, e.last});
                        chk($sformatf("mux_sel%0d", g), {28'd0, sel[g]}, {28'd0, e.sel});
                        chk($sformatf("mux_in%0d", g), {16'd0, min[g]}, {16'd0, word[g]});
                    end
                    hs[g]++;
                end else begin
                    hold_v = 1'b1;
                    hold   = {sb[g], sl[g], sel[g]};
                end
            end else begin
                hold_v = 1'b0;
            end
            if (dn[g]) dones[g]++;
        end
    end

    task automatic run(input int g, input logic [15:0] d, input logic [4:0] c,
                       input int stall_len, input int poke_at, input int abort_at);
        int   n, t0, tdone, hs0, dn0, left, it;
        logic [3:0] s;
        n = (c == 0 || c > 16) ? 16 : int'(c);
        word[g] = d;
        for (int i = 0; i < n; i++) begin
            s = (g == 1) ? 4'(15 - i) : 4'(i);
            q[g].push_back('{b: d[s], last: (i == n - 1), sel: s});
        end
        hs0 = hs[g]; dn0 = dones[g]; left = stall_len; tdone = -1;
        din[g] = d; cnt[g] = c; st[g] = 1'b1; t0 = cyc;
        for (it = 0; it < 400; it++) begin
            @(posedge clk); #1;
            st[g] = 1'b0;
            if (it == poke_at) begin
                st[g]  = 1'b1;
                din[g] = 16'hFFFF;
            end
            if (dn[g] && tdone < 0) tdone = cyc - t0;
            if (abort_at > 0 && hs[g] - hs0 == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_outs", {7'd0, min[g], sel[g], sb[g], sv[g], sl[g], bsy[g], dn[g]}, '0);
                q[g].delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                chk("reset_no_done", 32'(dones[g] - dn0), 0);
                break;
            end
            if (left > 0 && sv[g] && hs[g] - hs0 == 1) begin
                rdy[g] = 1'b0;
                left--;
            end else begin
                rdy[g] = 1'b1;
            end
            if (!bsy[g]) break;
        end
        rdy[g] = 1'b1;
        if (abort_at <= 0) begin
            chk($sformatf("busy_cycles%0d_n%0d", g, n), 32'(cyc - t0), 32'(2 * n + 2 + stall_len));
            chk($sformatf("done_at%0d_n%0d", g, n), 32'(tdone), 32'(2 * n + 1 + stall_len));
            chk($sformatf("done_count%0d", g), 32'(dones[g] - dn0), 1);
            chk($sformatf("queue_empty%0d", g), 32'(q[g].size()), 0);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            st[g] = 1'b0; din[g] = '0; cnt[g] = '0; rdy[g] = 1'b1; hs[g] = 0; dones[g] = 0;
        end
        #2;
        for (int g = 0; g < 2; g++)
            chk($sformatf("reset_state%0d", g), {7'd0, min[g], sel[g], sb[g], sv[g], sl[g], bsy[g], dn[g]}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 16'hACF1, 5'd0,  0, -1, -1);  // full word LSB first
        run(1, 16'hACF1, 5'd4,  0, -1, -1);  // MSB first, 4 bits: 1,0,1,0
        run(0, 16'h5A3C, 5'd0,  7, -1, -1);  // 7-cycle stall on bit 2
        run(0, 16'h0001, 5'd0,  0,  6, -1);  // start while busy ignored
        run(0, 16'h0003, 5'd1,  0, -1, -1);  // single bit, back-to-back start
        run(0, 16'h8421, 5'd20, 0, -1, -1);  // oversize count clipped to 16
        run(0, 16'hC3A5, 5'd0,  0, -1,  5);  // reset after 5 bits
        run(0, 16'h0F0F, 5'd3,  0, -1, -1);  // normal start after reset

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
